// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches an 8-word block from main memory and streams it
// into the I- or D-cache data array, with the D-side winning simultaneous misses.
module cache_fill_fsm #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  output logic        i_stall,
  output logic        d_stall,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data,
  output logic        fill_we,
  output logic        fill_sel,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        fill_tag_we,
  output logic [15:0] fill_base
);

  localparam logic [3:0]  BLOCK_WORDS = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0]  LAST_WORD   = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [15:0] BLOCK_MASK  = ~16'(2 * WORDS_PER_BLOCK - 1);

  // Port widths (fill_word, 4-bit counters) are sized for an 8-word block only.
  if (WORDS_PER_BLOCK != 8 || MEM_LATENCY < 1) begin : g_param_check
    $error("cache_fill_fsm: unsupported parameterisation");
  end

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sel;
  logic [15:0] r_base;
  logic [3:0]  r_tx_cnt;
  logic [3:0]  r_rx_cnt;

  logic        w_start;
  logic        w_start_sel;
  logic [15:0] w_start_base;
  logic        w_issue;
  logic        w_recv;
  logic        w_last;

  always_comb begin
    w_start      = (r_state == IDLE) && (d_miss || i_miss);
    w_start_sel  = d_miss;
    w_start_base = d_miss ? (d_miss_addr & BLOCK_MASK) : (i_miss_addr & BLOCK_MASK);
    w_issue      = (r_state == FILL) && (r_tx_cnt < BLOCK_WORDS);
    w_recv       = (r_state == FILL) && mem_data_valid && (r_rx_cnt < BLOCK_WORDS);
    w_last       = w_recv && (r_rx_cnt == LAST_WORD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (d_miss || i_miss) w_state_nxt = FILL;
      FILL: if (w_last)           w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Base and target are captured once per fill; later miss-address changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel    <= 1'b0;
      r_base   <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else if (w_start) begin
      r_sel    <= w_start_sel;
      r_base   <= w_start_base;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_issue) r_tx_cnt <= r_tx_cnt + 4'd1;
      if (w_recv)  r_rx_cnt <= r_rx_cnt + 4'd1;
    end
  end

  always_comb begin
    i_stall     = i_miss || ((r_state == FILL) && !r_sel);
    d_stall     = d_miss || ((r_state == FILL) && r_sel);
    mem_en      = w_issue;
    mem_addr    = '0;
    fill_we     = w_recv;
    fill_sel    = 1'b0;
    fill_word   = '0;
    fill_data   = '0;
    fill_tag_we = w_last;
    fill_base   = r_base;
    if (w_issue) begin
      mem_addr = r_base + {11'd0, r_tx_cnt, 1'b0};
    end
    if (w_recv) begin
      fill_sel  = r_sel;
      fill_word = r_rx_cnt[2:0];
      fill_data = mem_data;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: per-cycle stimulus with hand-derived expected outputs.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0;
  logic [15:0] i_miss_addr = '0;
  logic        d_miss = 1'b0;
  logic [15:0] d_miss_addr = '0;
  logic        i_stall, d_stall, mem_en, fill_we, fill_sel, fill_tag_we;
  logic [15:0] mem_addr, fill_data, fill_base;
  logic [2:0]  fill_word;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = '0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  string       cur_test = "reset";
  int          cur_cyc = 0;
  logic [15:0] prev_base = '0;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .i_stall(i_stall), .d_stall(d_stall),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word),
    .fill_data(fill_data), .fill_tag_we(fill_tag_we), .fill_base(fill_base)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s cycle %0d: got %h, expected %h", cur_test, tag, cur_cyc, got, exp);
    end
  endtask

  // Entered just after a rising edge: drive one cycle of inputs, check mid-cycle, advance.
  task automatic tick(input logic t_rst, input logic im, input logic [15:0] ia,
                      input logic dm, input logic [15:0] da,
                      input logic v, input logic [15:0] md,
                      input logic x_is, input logic x_ds, input logic x_me,
                      input logic [15:0] x_ma, input logic x_we, input logic x_sel,
                      input logic [2:0] x_wd, input logic x_tag, input logic [15:0] x_base);
    rst = t_rst; i_miss = im; i_miss_addr = ia; d_miss = dm; d_miss_addr = da;
    mem_data_valid = v; mem_data = md;
    #4;
    check_eq("i_stall",     16'(i_stall),     16'(x_is));
    check_eq("d_stall",     16'(d_stall),     16'(x_ds));
    check_eq("mem_en",      16'(mem_en),      16'(x_me));
    check_eq("mem_addr",    mem_addr,         x_me ? x_ma : 16'h0000);
    check_eq("fill_we",     16'(fill_we),     16'(x_we));
    check_eq("fill_sel",    16'(fill_sel),    x_we ? 16'(x_sel) : 16'h0000);
    check_eq("fill_word",   16'(fill_word),   x_we ? 16'(x_wd) : 16'h0000);
    check_eq("fill_data",   fill_data,        x_we ? md : 16'h0000);
    check_eq("fill_tag_we", 16'(fill_tag_we), 16'(x_tag));
    check_eq("fill_base",   fill_base,        x_base);
    @(posedge clk);
    #1;
  endtask

  task automatic spurious_idle(input string name);
    cur_test = name;
    for (int c = 0; c < 6; c++) begin
      cur_cyc = c;
      tick(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF,
           1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000);
    end
  endtask

  initial begin
    logic [31:0] vmask;
    int          nrx;
    logic        v;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    spurious_idle("idle_after_reset");

    cur_test = "i_single";
    for (int c = 0; c <= 14; c++) begin
      cur_cyc = c;
      v = (c >= 5 && c <= 12);
      tick(1'b0, c <= 12, 16'h0046, 1'b0, 16'h0000, v, 16'hC000 + 16'(c),
           c <= 12, 1'b0, (c >= 1 && c <= 8), 16'h0040 + 16'(2 * (c - 1)),
           v, 1'b0, 3'(c - 5), c == 12, (c == 0) ? prev_base : 16'h0040);
    end
    prev_base = 16'h0040;

    cur_test = "d_wins";
    for (int c = 0; c <= 27; c++) begin
      logic me;
      logic [15:0] ma;
      logic [15:0] b;
      cur_cyc = c;
      v  = (c >= 5 && c <= 12) || (c >= 18 && c <= 25);
      me = (c >= 1 && c <= 8) || (c >= 14 && c <= 21);
      ma = (c <= 8) ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0010 + 16'(2 * (c - 14));
      b  = (c == 0) ? prev_base : ((c <= 13) ? 16'h1230 : 16'h0010);
      tick(1'b0, c <= 25, 16'h0010, c <= 12, 16'h1234, v, 16'h5A00 + 16'(c),
           c <= 25, c <= 12, me, ma, v, c <= 12,
           (c <= 12) ? 3'(c - 5) : 3'(c - 18), (c == 12) || (c == 25), b);
    end
    prev_base = 16'h0010;

    cur_test = "bubbles";
    vmask = 32'h0001CE60;
    nrx = 0;
    for (int c = 0; c <= 18; c++) begin
      cur_cyc = c;
      v = vmask[c];
      tick(1'b0, c <= 16, 16'h020A, 1'b0, 16'h0000, v, 16'h7700 + 16'(c),
           c <= 16, 1'b0, (c >= 1 && c <= 8), 16'h0200 + 16'(2 * (c - 1)),
           v, 1'b0, 3'(nrx), c == 16, (c == 0) ? prev_base : 16'h0200);
      if (v) nrx++;
    end
    check_eq("bubble_word_count", 16'(nrx), 16'd8);
    prev_base = 16'h0200;

    cur_test = "reset_mid_fill";
    for (int c = 0; c <= 13; c++) begin
      logic [15:0] b;
      cur_cyc = c;
      v = (c >= 5 && c <= 12);
      b = (c == 0) ? prev_base : ((c <= 7) ? 16'h0100 : 16'h0000);
      tick(c == 7, c <= 7, 16'h0104, 1'b0, 16'h0000, v, 16'h3300 + 16'(c),
           c <= 7, 1'b0, (c >= 1 && c <= 7), 16'h0100 + 16'(2 * (c - 1)),
           v && (c <= 7), 1'b0, 3'(c - 5), 1'b0, b);
    end
    prev_base = 16'h0000;

    spurious_idle("idle_after_mid_reset");

    cur_test = "d_addr_change";
    for (int c = 0; c <= 14; c++) begin
      cur_cyc = c;
      v = (c >= 5 && c <= 12);
      tick(1'b0, 1'b0, 16'h0000, c <= 12, (c >= 3) ? 16'h3000 : 16'h2000, v, 16'h9100 + 16'(c),
           1'b0, c <= 12, (c >= 1 && c <= 8), 16'h2000 + 16'(2 * (c - 1)),
           v, 1'b1, 3'(c - 5), c == 12, (c == 0) ? prev_base : 16'h2000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
